// File: rtl/time_clock_pkg.sv
// Shared definitions for the clock time-set logic: FSM encoding, field limits
// and the wrap-around increment used on the hour and minute shadows.
package time_clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
    return (value == max) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button, live-time and load/display signals between the time-set controller
// and its surroundings (time counter, display driver, button debouncers).
interface time_set_controller_if;
  logic       i_btn_mode;
  logic       i_btn_sel;
  logic       i_btn_inc;
  logic [5:0] i_hour;
  logic [5:0] i_min;
  logic       o_run_en;
  logic       o_load;
  logic [5:0] o_load_hour;
  logic [5:0] o_load_min;
  logic       o_disp_sel;
  logic [3:0] o_blank;
  logic [1:0] o_state;

  modport slave (
    input  i_btn_mode, i_btn_sel, i_btn_inc, i_hour, i_min,
    output o_run_en, o_load, o_load_hour, o_load_min, o_disp_sel, o_blank, o_state
  );

  modport master (
    output i_btn_mode, i_btn_sel, i_btn_inc, i_hour, i_min,
    input  o_run_en, o_load, o_load_hour, o_load_min, o_disp_sel, o_blank, o_state
  );
endinterface

// File: rtl/blink_timer.sv
// Blink half-period timer: phase toggles every BLINK_HALF enabled cycles,
// strobe marks the cycle on which it toggles. Disable or restart returns to phase 0.
module blink_timer #(
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic phase,
  output logic strobe
);
  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt_reg;
  logic          phase_reg;

  assign strobe = enable && !restart && (cnt_reg == LAST);
  assign phase  = phase_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (!enable || restart) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (strobe) begin
      cnt_reg   <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/time_set_controller.sv
// Time-set FSM: captures live time into shadows, edits hour/minute with
// blinking feedback, commits with a one-cycle load or abandons on inactivity.
module time_set_controller
  import time_clock_pkg::*;
#(
  parameter int BLINK_HALF     = 25_000_000,
  parameter int TIMEOUT_HALVES = 20
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  time_set_controller_if.slave  bus
);
  localparam int IW = $clog2(TIMEOUT_HALVES + 1);
  localparam logic [IW-1:0] INACT_LAST = IW'(TIMEOUT_HALVES - 1);

  state_t        state_reg, state_next;
  logic [5:0]    hour_reg, hour_next;
  logic [5:0]    min_reg, min_next;
  logic [IW-1:0] inact_reg, inact_next;
  logic          load_reg;
  logic          in_set;
  logic          restart;
  logic          phase;
  logic          strobe;
  logic [3:0]    blank;

  assign in_set  = (state_reg == ST_SET_HOUR) || (state_reg == ST_SET_MIN);
  // mode leaves the SET states, so only sel/inc need to restart the blink
  assign restart = in_set && (bus.i_btn_sel || bus.i_btn_inc);

  blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .enable  (in_set),
    .restart (restart),
    .phase   (phase),
    .strobe  (strobe)
  );

  always_comb begin
    state_next = state_reg;
    hour_next  = hour_reg;
    min_next   = min_reg;
    inact_next = inact_reg;
    case (state_reg)
      ST_RUN: begin
        if (bus.i_btn_mode) begin
          state_next = ST_SET_HOUR;
          hour_next  = bus.i_hour;
          min_next   = bus.i_min;
          inact_next = '0;
        end
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        if (bus.i_btn_mode) begin
          state_next = ST_COMMIT;
          inact_next = '0;
        end else if (bus.i_btn_sel) begin
          state_next = (state_reg == ST_SET_HOUR) ? ST_SET_MIN : ST_SET_HOUR;
          inact_next = '0;
        end else if (bus.i_btn_inc) begin
          if (state_reg == ST_SET_HOUR) hour_next = wrap_inc(hour_reg, HOUR_MAX);
          else                          min_next  = wrap_inc(min_reg, MIN_MAX);
          inact_next = '0;
        end else if (strobe) begin
          if (inact_reg == INACT_LAST) begin
            state_next = ST_RUN;
            inact_next = '0;
          end else begin
            inact_next = inact_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_RUN;
        inact_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= ST_RUN;
      hour_reg  <= '0;
      min_reg   <= '0;
      inact_reg <= '0;
      load_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hour_reg  <= hour_next;
      min_reg   <= min_next;
      inact_reg <= inact_next;
      load_reg  <= (state_next == ST_COMMIT);
    end
  end

  // upper two digits blink for the hour field, lower two for the minute field
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_blank
      if (gi >= 2) begin : g_hour
        assign blank[gi] = phase && (state_reg == ST_SET_HOUR);
      end else begin : g_min
        assign blank[gi] = phase && (state_reg == ST_SET_MIN);
      end
    end
  endgenerate

  assign bus.o_run_en    = (state_reg == ST_RUN);
  assign bus.o_load      = load_reg;
  assign bus.o_load_hour = hour_reg;
  assign bus.o_load_min  = min_reg;
  assign bus.o_disp_sel  = in_set;
  assign bus.o_blank     = blank;
  assign bus.o_state     = state_reg;
endmodule

// File: tb/tb_time_set_controller.sv
// Randomized and directed bench for time_set_controller against a behavioural
// model that tracks idle time in the set states as a plain cycle count.
module tb_time_set_controller;
  localparam int BH = 4;
  localparam int TH = 3;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  time_set_controller_if bus ();

  time_set_controller #(.BLINK_HALF(BH), .TIMEOUT_HALVES(TH)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;

  // model: state code, shadow values, cycles spent in SET since entry/sel/inc
  int m_st = 0, m_h = 0, m_m = 0, m_idle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_st = 0; m_h = 0; m_m = 0; m_idle = 0;
    end else begin
      case (m_st)
        0: if (bus.i_btn_mode) begin
             m_st = 1; m_h = bus.i_hour; m_m = bus.i_min; m_idle = 0;
           end
        1, 2: begin
          if (bus.i_btn_mode) m_st = 3;
          else if (bus.i_btn_sel) begin m_st = 3 - m_st; m_idle = 0; end
          else if (bus.i_btn_inc) begin
            if (m_st == 1) m_h = (m_h + 1) % 24;
            else           m_m = (m_m + 1) % 60;
            m_idle = 0;
          end else begin
            m_idle++;
            if (m_idle == BH * TH) m_st = 0;
          end
        end
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (i_reset === 1'b1) begin
      logic [3:0] exp_blank;
      bit ph;
      ph = ((m_idle / BH) % 2) == 1;
      exp_blank = (m_st == 1 && ph) ? 4'b1100 : (m_st == 2 && ph) ? 4'b0011 : 4'b0000;
      check("state",     32'(bus.o_state),     32'(m_st));
      check("run_en",    32'(bus.o_run_en),    32'(m_st == 0));
      check("load",      32'(bus.o_load),      32'(m_st == 3));
      check("disp_sel",  32'(bus.o_disp_sel),  32'(m_st == 1 || m_st == 2));
      check("blank",     32'(bus.o_blank),     32'(exp_blank));
      check("load_hour", 32'(bus.o_load_hour), 32'(m_h));
      check("load_min",  32'(bus.o_load_min),  32'(m_m));
    end
  end

  always @(negedge i_clk) if (bus.o_load === 1'b1) load_cnt++;

  task automatic drive(input bit m, input bit s, input bit n);
    bus.i_btn_mode = m; bus.i_btn_sel = s; bus.i_btn_inc = n;
    @(posedge i_clk); #1;
    bus.i_btn_mode = 1'b0; bus.i_btn_sel = 1'b0; bus.i_btn_inc = 1'b0;
    if (m || s || n)
      $display("txn mode=%0b sel=%0b inc=%0b -> state=%0d shadow=%0d:%0d",
               m, s, n, bus.o_state, bus.o_load_hour, bus.o_load_min);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},  32'(bus.o_state),     32'd0);
    check({tag, "_run_en"}, 32'(bus.o_run_en),    32'd1);
    check({tag, "_load"},   32'(bus.o_load),      32'd0);
    check({tag, "_disp"},   32'(bus.o_disp_sel),  32'd0);
    check({tag, "_blank"},  32'(bus.o_blank),     32'd0);
    check({tag, "_hour"},   32'(bus.o_load_hour), 32'd0);
    check({tag, "_min"},    32'(bus.o_load_min),  32'd0);
  endtask

  initial begin
    int base;
    bus.i_btn_mode = 0; bus.i_btn_sel = 0; bus.i_btn_inc = 0;
    bus.i_hour = 6'd0; bus.i_min = 6'd0;
    i_reset = 1'b1;
    #1 i_reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge i_clk);
    #3 i_reset = 1'b1;
    @(posedge i_clk); #1;

    // Scenario 6: sel/inc ignored in RUN
    bus.i_hour = 6'd7; bus.i_min = 6'd45;
    drive(0, 1, 0); check("s6_sel_state", 32'(bus.o_state), 32'd0);
    drive(0, 0, 1); check("s6_inc_run", 32'(bus.o_run_en), 32'd1);
    drive(0, 1, 1); check("s6_shadow_h", 32'(bus.o_load_hour), 32'd0);

    // Scenario 1: 22:58 -> 00:00 with hour and minute wrap
    bus.i_hour = 6'd22; bus.i_min = 6'd58;
    base = load_cnt;
    drive(1, 0, 0); check("s1_capture_h", 32'(bus.o_load_hour), 32'd22);
    drive(0, 0, 1); drive(0, 0, 1); check("s1_hour_wrap", 32'(bus.o_load_hour), 32'd0);
    drive(0, 1, 0); check("s1_sel_min", 32'(bus.o_state), 32'd2);
    drive(0, 0, 1); check("s1_min59", 32'(bus.o_load_min), 32'd59);
    drive(0, 0, 1);
    drive(1, 0, 0);
    check("s1_commit_state", 32'(bus.o_state), 32'd3);
    check("s1_commit_load",  32'(bus.o_load), 32'd1);
    check("s1_commit_hm",    32'({bus.o_load_hour, bus.o_load_min}), 32'd0);
    drive(0, 0, 0);
    check("s1_back_run", 32'(bus.o_state), 32'd0);
    check("s1_load_once", 32'(load_cnt - base), 32'd1);

    // Scenario 2: 60 minute increments return to captured minute
    bus.i_hour = 6'd9; bus.i_min = 6'd17;
    drive(1, 0, 0); drive(0, 1, 0);
    for (int k = 1; k <= 60; k++) begin
      drive(0, 0, 1);
      if (k == 42) check("s2_min59", 32'(bus.o_load_min), 32'd59);
      if (k == 43) check("s2_min_wrap", 32'(bus.o_load_min), 32'd0);
    end
    check("s2_min_end", 32'(bus.o_load_min), 32'd17);
    check("s2_hour", 32'(bus.o_load_hour), 32'd9);
    drive(1, 0, 0); drive(0, 0, 0);

    // Scenario 3: simultaneous mode/sel/inc -> mode wins
    bus.i_hour = 6'd5; bus.i_min = 6'd30;
    base = load_cnt;
    drive(1, 0, 0);
    drive(1, 1, 1);
    check("s3_commit", 32'(bus.o_state), 32'd3);
    check("s3_hm", 32'({bus.o_load_hour, bus.o_load_min}), 32'({6'd5, 6'd30}));
    drive(1, 1, 1);
    check("s3_run", 32'(bus.o_state), 32'd0);
    check("s3_load_once", 32'(load_cnt - base), 32'd1);
    drive(0, 0, 0);

    // Scenario 4: blink and inactivity timeout with no load
    base = load_cnt;
    drive(1, 0, 0);
    check("s4_blank0", 32'(bus.o_blank), 32'd0);
    for (int k = 1; k <= BH * TH; k++) begin
      drive(0, 0, 0);
      if (k < BH * TH)
        check("s4_blank", 32'(bus.o_blank), (k >= 4 && k < 8) ? 32'hC : 32'h0);
    end
    check("s4_timeout_run", 32'(bus.o_state), 32'd0);
    check("s4_no_load", 32'(load_cnt - base), 32'd0);

    // Scenario 5: async reset mid SET_MIN
    drive(1, 0, 0); drive(0, 1, 0);
    check("s5_in_setmin", 32'(bus.o_state), 32'd2);
    #3 i_reset = 1'b0;
    #1 check_reset_outputs("s5");
    repeat (2) @(posedge i_clk);
    #3 i_reset = 1'b1;
    base = load_cnt;
    @(posedge i_clk); #1;
    check("s5_first_run", 32'(bus.o_run_en), 32'd1);
    repeat (5) drive(0, 0, 0);
    check("s5_no_load", 32'(load_cnt - base), 32'd0);

    // randomized traffic, alternating sparse (timeout-prone) and dense segments
    for (int seg = 0; seg < 24; seg++) begin
      for (int c = 0; c < 30; c++) begin
        int thr;
        logic [2:0] b;
        if ($urandom_range(0, 9) == 0) begin
          bus.i_hour = 6'($urandom_range(0, 23));
          bus.i_min  = 6'($urandom_range(0, 59));
        end
        thr = (seg % 3 == 0) ? 2 : 30;
        b = 3'b000;
        if ($urandom_range(0, 99) < thr) b = 3'($urandom_range(1, 7));
        if (b[2] && $urandom_range(0, 2) != 0) b[2] = 1'b0;
        drive(b[2], b[1], b[0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
